// File: rtl/multicore_mem_arbiter_pkg.sv
// Shared types and helpers for the multicore data-memory arbiter.
package multicore_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_CORES = 16;

  // Width of a core index / round-robin pointer; never below one bit.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicore_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the scan just above the last winner.
module rr_arbiter
  import multicore_mem_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = ptrWidth(N)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          hit;

  // First pass takes cores above the pointer, second pass wraps to the bottom.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit && req[i] && (i > int'(ptr))) begin
        hit    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!hit && req[i]) begin
        hit    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    if (!en) begin
      gnt = '0;
      idx = '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr <= IW'(N - 1);
    end else if (|gnt) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Start broadcast, round-robin data-memory arbitration and completion collection for a core array.
//
// state | meaning
// IDLE  | ready, waiting for start
// START | one-cycle start pulse to all cores, sticky done cleared
// RUN   | cores arbitrated onto memory, done bits collected
// DONE  | all cores finished, ready for a new start
module multicore_mem_arbiter
  import multicore_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES           = 4,
  parameter int REG_WIDTH           = 12,
  parameter int DATA_MEM_ADDR_WIDTH = 12
) (
  input  logic                                     clk,
  input  logic                                     rstN,
  input  logic                                     start,
  input  logic [NUM_CORES-1:0]                     coreReq,
  input  logic [NUM_CORES-1:0]                     coreWrEn,
  input  logic [NUM_CORES*DATA_MEM_ADDR_WIDTH-1:0] coreAddr,
  input  logic [NUM_CORES*REG_WIDTH-1:0]           coreDataOut,
  input  logic [NUM_CORES-1:0]                     coreDone,
  input  logic [REG_WIDTH-1:0]                     memDataOut,
  output logic [NUM_CORES-1:0]                     coreStart,
  output logic [NUM_CORES-1:0]                     coreGnt,
  output logic [NUM_CORES-1:0]                     coreRdValid,
  output logic [REG_WIDTH-1:0]                     coreDataIn,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]           memAddr,
  output logic [REG_WIDTH-1:0]                     memDataIn,
  output logic                                     memWrEn,
  output logic                                     ready,
  output logic                                     done
);

  localparam int IW = ptrWidth(NUM_CORES);

  state_t               state;
  logic [NUM_CORES-1:0] stickyDone;
  logic [NUM_CORES-1:0] allDone;
  logic [NUM_CORES-1:0] rdValid;
  logic [NUM_CORES-1:0] gnt;
  logic [IW-1:0]        gntIdx;
  logic                 anyGnt;
  logic                 arbEn;

  assign arbEn   = (state == RUN);
  assign anyGnt  = |gnt;
  assign allDone = stickyDone | coreDone;

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IW)
  ) uArb (
    .clk  (clk),
    .rstN (rstN),
    .req  (coreReq),
    .en   (arbEn),
    .gnt  (gnt),
    .idx  (gntIdx)
  );

  assign coreGnt     = gnt;
  assign coreRdValid = rdValid;
  assign coreDataIn  = memDataOut;

  always_comb begin
    memAddr   = '0;
    memDataIn = '0;
    memWrEn   = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) begin
        memAddr   = coreAddr[i*DATA_MEM_ADDR_WIDTH +: DATA_MEM_ADDR_WIDTH];
        memDataIn = coreDataOut[i*REG_WIDTH +: REG_WIDTH];
        memWrEn   = coreWrEn[i];
      end
    end
  end

  // Runs in every state so a read granted on the last RUN cycle still returns.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdValid <= '0;
    end else if (anyGnt && !coreWrEn[gntIdx]) begin
      rdValid <= gnt;
    end else begin
      rdValid <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      stickyDone <= '0;
      coreStart  <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= START;
            coreStart <= '1;
            ready     <= 1'b0;
          end
        end
        START: begin
          state      <= RUN;
          coreStart  <= '0;
          stickyDone <= '0;
        end
        RUN: begin
          stickyDone <= allDone;
          if (&allDone) begin
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state     <= START;
            coreStart <= '1;
            ready     <= 1'b0;
            done      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          coreStart <= '0;
          ready     <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Directed bench for multicore_mem_arbiter with a registered-read memory model.
module tb_multicore_mem_arbiter;

  localparam int NC = 4;
  localparam int RW = 12;
  localparam int AW = 12;

  logic            clk;
  logic            rstN;
  logic            start;
  logic [NC-1:0]   coreReq;
  logic [NC-1:0]   coreWrEn;
  logic [NC*AW-1:0] coreAddr;
  logic [NC*RW-1:0] coreDataOut;
  logic [NC-1:0]   coreDone;
  logic [RW-1:0]   memDataOut;
  logic [NC-1:0]   coreStart;
  logic [NC-1:0]   coreGnt;
  logic [NC-1:0]   coreRdValid;
  logic [RW-1:0]   coreDataIn;
  logic [AW-1:0]   memAddr;
  logic [RW-1:0]   memDataIn;
  logic            memWrEn;
  logic            ready;
  logic            done;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] mem [0:(1<<AW)-1];
  logic [NC-1:0] expGnt;

  multicore_mem_arbiter #(
    .NUM_CORES           (NC),
    .REG_WIDTH           (RW),
    .DATA_MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .coreReq     (coreReq),
    .coreWrEn    (coreWrEn),
    .coreAddr    (coreAddr),
    .coreDataOut (coreDataOut),
    .coreDone    (coreDone),
    .memDataOut  (memDataOut),
    .coreStart   (coreStart),
    .coreGnt     (coreGnt),
    .coreRdValid (coreRdValid),
    .coreDataIn  (coreDataIn),
    .memAddr     (memAddr),
    .memDataIn   (memDataIn),
    .memWrEn     (memWrEn),
    .ready       (ready),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWrEn) mem[memAddr] <= memDataIn;
    memDataOut <= mem[memAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstN        = 1'b0;
    start       = 1'b0;
    coreReq     = '0;
    coreWrEn    = '0;
    coreAddr    = '0;
    coreDataOut = '0;
    coreDone    = '0;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_gnt", coreGnt, 0);
    chk("rst_start", coreStart, 0);
    chk("rst_rdvalid", coreRdValid, 0);
    chk("rst_memwr", memWrEn, 0);
    chk("rst_memaddr", memAddr, 0);
    chk("rst_memdin", memDataIn, 0);

    // IDLE with requests: no grants
    next(); rstN = 1'b1; coreReq = 4'hF; mid();
    chk("idle_gnt", coreGnt, 0);
    chk("idle_ready", ready, 1);

    next(); start = 1'b1; mid();
    chk("idle2_gnt", coreGnt, 0);

    // START cycle
    next(); start = 1'b0; mid();
    chk("start_pulse", coreStart, 4'hF);
    chk("start_ready", ready, 0);
    chk("start_gnt", coreGnt, 0);

    // RUN, with a stray start that must be ignored
    next(); start = 1'b1; mid();
    chk("run_start_off", coreStart, 0);
    chk("run_ready", ready, 0);
    chk("rr_gnt0", coreGnt, 4'b0001);

    for (int k = 1; k < 8; k++) begin
      next(); start = 1'b0; mid();
      expGnt = 4'b0001 << (k % 4);
      chk("rr_gnt", coreGnt, expGnt);
      chk("rr_ready", ready, 0);
      chk("rr_start", coreStart, 0);
    end

    coreReq = 4'b1010;
    next(); mid();
    chk("alt_gnt_a", coreGnt, 4'b0010);
    chk("alt_rdvalid", coreRdValid, 4'b1000);
    next(); mid(); chk("alt_gnt_b", coreGnt, 4'b1000);
    next(); mid(); chk("alt_gnt_c", coreGnt, 4'b0010);
    next(); mid(); chk("alt_gnt_d", coreGnt, 4'b1000);

    // core 2 write then read
    next();
    coreReq  = 4'b0100;
    coreWrEn = 4'b0100;
    coreAddr[2*AW +: AW]    = 12'h010;
    coreDataOut[2*RW +: RW] = 12'hABC;
    mid();
    chk("wr_gnt", coreGnt, 4'b0100);
    chk("wr_memwr", memWrEn, 1);
    chk("wr_addr", memAddr, 12'h010);
    chk("wr_data", memDataIn, 12'hABC);
    chk("wr_prev_rdvalid", coreRdValid, 4'b1000);

    next(); coreWrEn = 4'b0000; mid();
    chk("rd_gnt", coreGnt, 4'b0100);
    chk("rd_memwr", memWrEn, 0);
    chk("rd_after_wr_rdvalid", coreRdValid, 0);

    next(); coreReq = 4'b0000; mid();
    chk("rd_rdvalid", coreRdValid, 4'b0100);
    chk("rd_data", coreDataIn, 12'hABC);
    chk("nogrant_gnt", coreGnt, 0);
    chk("nogrant_addr", memAddr, 0);
    chk("nogrant_wr", memWrEn, 0);

    // completion pulses 0,3,1,2
    next(); coreDone = 4'b0001; mid(); chk("done_c1", done, 0);
    next(); coreDone = 4'b1000; mid(); chk("done_c2", done, 0);
    next(); coreDone = 4'b0010; mid(); chk("done_c3", done, 0);
    next();
    coreDone = 4'b0100;
    coreReq  = 4'b0001;
    coreAddr[0 +: AW] = 12'h010;
    mid();
    chk("done_c4", done, 0);
    chk("done_c4_gnt", coreGnt, 4'b0001);
    chk("done_c4_addr", memAddr, 12'h010);

    next(); coreDone = 4'b0000; coreReq = 4'hF; start = 1'b1; mid();
    chk("done_up", done, 1);
    chk("done_ready", ready, 1);
    chk("done_rdvalid", coreRdValid, 4'b0001);
    chk("done_rddata", coreDataIn, 12'hABC);
    chk("done_gnt", coreGnt, 0);

    next(); start = 1'b0; mid();
    chk("restart_done", done, 0);
    chk("restart_ready", ready, 0);
    chk("restart_pulse", coreStart, 4'hF);
    chk("restart_gnt", coreGnt, 0);

    next(); mid();
    chk("run2_gnt_a", coreGnt, 4'b0010);
    next(); mid();
    chk("run2_gnt_b", coreGnt, 4'b0100);
    chk("run2_rdvalid", coreRdValid, 4'b0010);

    // asynchronous reset mid-RUN with reads in flight
    #1 rstN = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_done", done, 0);
    chk("arst_rdvalid", coreRdValid, 0);
    chk("arst_gnt", coreGnt, 0);
    chk("arst_start", coreStart, 0);

    next(); rstN = 1'b1; start = 1'b1; mid();
    chk("post_idle_gnt", coreGnt, 0);
    next(); start = 1'b0; mid();
    chk("post_start", coreStart, 4'hF);
    next(); mid();
    chk("post_first_gnt", coreGnt, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicore_mem_arbiter.md
Name: multicore_mem_arbiter

Overview:
- Couples NUM_CORES processor cores to one shared single-port synchronous data memory.
- Broadcasts a global start to all cores and round-robin arbitrates their data-memory read/write accesses, one per cycle.
- Collects per-core completion into global done/ready.
- Sits between the core array and the data memory in the multicore top level.

Parameters:
- NUM_CORES, 4, number of processor cores served (2..16).
- REG_WIDTH, 12, data word width.
- DATA_MEM_ADDR_WIDTH, 12, data memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- start  input  1  global start request.
- coreReq  input  NUM_CORES  per-core access request; held until granted.
- coreWrEn  input  NUM_CORES  per-core access type, 1=write, 0=read.
- coreAddr  input  NUM_CORES*DATA_MEM_ADDR_WIDTH  packed addresses; core i at slice i.
- coreDataOut  input  NUM_CORES*REG_WIDTH  packed write data.
- coreDone  input  NUM_CORES  per-core done level.
- memDataOut  input  REG_WIDTH  memory read data, valid one cycle after the address.
- coreStart  output  NUM_CORES  start pulse to every core.
- coreGnt  output  NUM_CORES  one-hot grant.
- coreRdValid  output  NUM_CORES  one-hot read-data valid.
- coreDataIn  output  REG_WIDTH  read data broadcast to all cores.
- memAddr  output  DATA_MEM_ADDR_WIDTH  memory address.
- memDataIn  output  REG_WIDTH  memory write data.
- memWrEn  output  1  memory write enable.
- ready  output  1  idle, accepting start.
- done  output  1  all cores finished.

Behaviour:
- Reset (rstN low, asynchronous):
  - state=IDLE; sticky done bits=0; rdValid register=0.
  - Round-robin pointer=NUM_CORES-1, so core 0 has first priority.
  - Resulting outputs: ready=1, done=0, coreStart=0, coreGnt=0, coreRdValid=0, memWrEn=0, memAddr=0, memDataIn=0.
  - Reset mid-RUN aborts all traffic; no pending rdValid survives.
- FSM:
  - IDLE: ready=1. start=1 -> START.
  - START: exactly one cycle; coreStart all ones; sticky done bits cleared -> RUN.
  - RUN: arbitrate. Sticky done bits |= coreDone. When (sticky | coreDone) is all ones -> DONE.
  - DONE: done=1, ready=1. start=1 -> START; done deasserts in the START cycle.
- start is ignored in START and RUN.
- Arbitration (RUN only; in all other states coreGnt=0 regardless of coreReq):
  - Combinational grant: the first requesting core scanning upward from pointer+1, wrapping at NUM_CORES-1 -> 0.
  - On grant to core k, the pointer becomes k on the next edge. With no request the pointer holds.
  - memAddr, memDataIn and memWrEn (=coreWrEn[k]) are driven combinationally from the granted core in the same cycle.
  - With no grant: memWrEn=0; memAddr and memDataIn = 0.
  - A core sees coreGnt[k]=1 for exactly the cycle its access is taken. It must drop or renew coreReq on the next cycle; a held request is a new access.
- Read latency: a read granted in cycle t gives coreRdValid[k]=1 in cycle t+1, with coreDataIn = memDataOut (combinational pass-through). coreRdValid is 0 for writes.
- A read granted in the same cycle the FSM leaves RUN still produces its rdValid one cycle later, in the DONE state.
- coreDone and coreReq from the same core in the same RUN cycle: the access is still granted and serviced.
- Fairness: with all cores requesting continuously, each core is granted once every NUM_CORES cycles.

Decomposition:
- Shared package:
  - State enum: IDLE, START, RUN, DONE (2 bits).
  - Helper constant for log2(NUM_CORES) pointer width.
- One sub-module: rr_arbiter.
  - Parameter N; inputs req, en; outputs one-hot gnt and index.
  - Owns the rotating pointer and its reset.
  - The top module holds the FSM, sticky done bits, muxing and rdValid register.

Test Plan:
- Reset then idle: rstN low for 2 cycles -> ready=1, done=0, all grants 0. Assert coreReq=4'b1111 in IDLE -> coreGnt stays 0.
- Start broadcast: start pulse in IDLE -> coreStart=4'b1111 for exactly one cycle, then RUN with ready=0. A second start during RUN is ignored.
- Round-robin fairness: coreReq=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Then coreReq=4'b1010 -> grants alternate 1,3.
- Write/read path: core 2 writes 12'hABC to address 12'h010, then reads 12'h010 -> memWrEn=1 in the write-grant cycle; coreRdValid=4'b0100 with coreDataIn=12'hABC the cycle after the read grant.
- Completion: coreDone raised for cores 0,3,1,2 on different cycles (pulses) -> done rises only the cycle after core 2's done. The read granted in that same cycle still returns rdValid. A following start clears done.
- Mid-operation reset: assert rstN low while RUN with pending reads -> immediately ready=1, done=0, coreRdValid=0. After release, the first grant goes to core 0.
